// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: ID-stage branch hazard stall, held PC redirect and IF/ID flush sequencing (optional BRANCH_STATS_EN counters)
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic            i_cbranch_decoded,
    input  logic            i_ubranch_decoded,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_jump_address,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    input  logic            i_uses_rs1,
    input  logic            i_uses_rs2,
    input  logic [4:0]      i_ex_rd_addr,
    input  logic            i_ex_reg_wr,
    input  logic [4:0]      i_mem_rd_addr,
    input  logic            i_mem_is_load,
    input  logic            i_fetch_ready,
    output logic            o_stall_id,
    output logic            o_pc_redirect,
    output logic [XLEN-1:0] o_pc_target,
    output logic            o_flush_if_id,
    output logic            o_misaligned
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     o_taken_cnt,
    output logic [31:0]     o_not_taken_cnt,
    output logic [31:0]     o_stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT_OPS, REDIRECT, FLUSH} state_t;
    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            w_br, w_haz1, w_haz2, w_hazard, w_taken, w_resolve;
    logic [XLEN-1:0] w_tgt;
    assign w_br      = i_cbranch_decoded | i_ubranch_decoded;
    assign w_haz1    = i_uses_rs1 && i_rs1_addr != 5'd0 &&
                       ((i_ex_reg_wr && i_rs1_addr == i_ex_rd_addr) || (i_mem_is_load && i_rs1_addr == i_mem_rd_addr));
    assign w_haz2    = i_uses_rs2 && i_rs2_addr != 5'd0 &&
                       ((i_ex_reg_wr && i_rs2_addr == i_ex_rd_addr) || (i_mem_is_load && i_rs2_addr == i_mem_rd_addr));
    assign w_hazard  = w_haz1 | w_haz2;
    assign w_taken   = i_ubranch_decoded | (i_cbranch_decoded & i_branch_taken);
    assign w_resolve = r_state == IDLE || r_state == WAIT_OPS;
    assign w_tgt     = i_jump_address & ~XLEN'(1);
    assign o_stall_id = (w_resolve & w_br & w_hazard) | (r_state == REDIRECT);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            o_pc_redirect <= 1'b0;
            o_pc_target   <= '0;
            o_flush_if_id <= 1'b0;
            o_misaligned  <= 1'b0;
        end else if (i_clk_en) begin
            o_misaligned <= 1'b0;
            unique case (r_state)
                IDLE, WAIT_OPS: begin
                    if (w_br && w_hazard) begin
                        r_state <= WAIT_OPS;
                    end else if (w_br && w_taken && w_tgt[1]) begin
                        o_misaligned <= 1'b1;
                        r_state      <= IDLE;
                    end else if (w_br && w_taken) begin
                        o_pc_target   <= w_tgt;
                        o_pc_redirect <= 1'b1;
                        o_flush_if_id <= 1'b1;
                        r_state       <= REDIRECT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REDIRECT: begin
                    if (i_fetch_ready) begin
                        o_pc_redirect <= 1'b0;
                        if (FLUSH_CYCLES > 0) begin
                            r_cnt   <= 4'(FLUSH_CYCLES - 1);
                            r_state <= FLUSH;
                        end else begin
                            o_flush_if_id <= 1'b0;
                            r_state       <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        o_flush_if_id <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end
`ifdef BRANCH_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_taken_cnt     <= '0;
            o_not_taken_cnt <= '0;
            o_stall_cnt     <= '0;
        end else if (i_clk_en && w_resolve && w_br) begin
            if (w_hazard) o_stall_cnt <= o_stall_cnt + 32'd1;
            if (!w_hazard && w_taken && !w_tgt[1]) o_taken_cnt <= o_taken_cnt + 32'd1;
            if (!w_hazard && !w_taken && i_cbranch_decoded) o_not_taken_cnt <= o_not_taken_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed vector table plus hand sequences for reset, clock-enable and flush corners
module tb_branch_redirect_ctrl;
    typedef struct {
        logic cb, ub, tk;
        logic [31:0] ja;
        logic [4:0] r1, r2;
        logic u1, u2;
        logic [4:0] exrd;
        logic exwr;
        logic [4:0] memrd;
        logic mld, fr;
        logic e_stall, e_red;
        logic [31:0] e_tgt;
        logic e_flush, e_mis;
    } vec_t;
    logic clk, rst, clk_en;
    logic cb, ub, tk, u1, u2, exwr, mld, fr;
    logic [31:0] ja;
    logic [4:0] r1, r2, exrd, memrd;
    logic stall, red, flush, mis;
    logic [31:0] tgt;
    int checks = 0;
    int errors = 0;
    vec_t v[20];
`ifdef BRANCH_STATS_EN
    logic [31:0] tcnt, ntcnt, scnt;
`endif
    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
        .i_cbranch_decoded(cb), .i_ubranch_decoded(ub), .i_branch_taken(tk),
        .i_jump_address(ja), .i_rs1_addr(r1), .i_rs2_addr(r2),
        .i_uses_rs1(u1), .i_uses_rs2(u2), .i_ex_rd_addr(exrd), .i_ex_reg_wr(exwr),
        .i_mem_rd_addr(memrd), .i_mem_is_load(mld), .i_fetch_ready(fr),
        .o_stall_id(stall), .o_pc_redirect(red), .o_pc_target(tgt),
        .o_flush_if_id(flush), .o_misaligned(mis)
`ifdef BRANCH_STATS_EN
        , .o_taken_cnt(tcnt), .o_not_taken_cnt(ntcnt), .o_stall_cnt(scnt)
`endif
    );
    initial clk = 0;
    always #5 clk = ~clk;
    function automatic vec_t mk(logic c, logic u, logic t, logic [31:0] a, logic [4:0] s1, logic [4:0] s2,
                                logic us1, logic us2, logic [4:0] erd, logic ewr, logic [4:0] mrd, logic ml,
                                logic f, logic es, logic er, logic [31:0] et, logic ef, logic em);
        vec_t x;
        x = '{c, u, t, a, s1, s2, us1, us2, erd, ewr, mrd, ml, f, es, er, et, ef, em};
        return x;
    endfunction
    function automatic vec_t idl(logic f, logic es, logic er, logic [31:0] et, logic ef, logic em);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, f, es, er, et, ef, em);
    endfunction
    task automatic apply(input vec_t x);
        cb = x.cb; ub = x.ub; tk = x.tk; ja = x.ja; r1 = x.r1; r2 = x.r2; u1 = x.u1; u2 = x.u2;
        exrd = x.exrd; exwr = x.exwr; memrd = x.memrd; mld = x.mld; fr = x.fr;
    endtask
    task automatic chk(input string n, input int idx, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", n, idx, a, e);
        end
    endtask
    task automatic chk_regs(input int idx, input logic er, input logic [31:0] et, input logic ef, input logic em);
        chk("pc_redirect", idx, {31'd0, red}, {31'd0, er});
        chk("pc_target", idx, tgt, et);
        chk("flush_if_id", idx, {31'd0, flush}, {31'd0, ef});
        chk("misaligned", idx, {31'd0, mis}, {31'd0, em});
    endtask
    initial begin
        v[0]  = mk(1, 0, 1, 32'h1000, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 32'h1000, 1, 0);
        v[1]  = idl(1, 1, 0, 32'h1000, 1, 0);
        v[2]  = idl(1, 0, 0, 32'h1000, 0, 0);
        v[3]  = idl(1, 0, 0, 32'h1000, 0, 0);
        v[4]  = mk(1, 0, 1, 32'h3000, 5, 0, 1, 0, 5, 1, 0, 0, 0, 1, 0, 32'h1000, 0, 0);
        v[5]  = mk(1, 0, 1, 32'h3000, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 32'h3000, 1, 0);
        v[6]  = idl(1, 1, 0, 32'h3000, 1, 0);
        v[7]  = idl(1, 0, 0, 32'h3000, 0, 0);
        v[8]  = mk(0, 1, 0, 32'h2003, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h3000, 0, 1);
        v[9]  = idl(1, 0, 0, 32'h3000, 0, 0);
        v[10] = mk(0, 1, 0, 32'h0400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0400, 1, 0);
        v[11] = idl(0, 1, 1, 32'h0400, 1, 0);
        v[12] = mk(1, 0, 1, 32'h0800, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0400, 1, 0);
        v[13] = idl(0, 1, 1, 32'h0400, 1, 0);
        v[14] = idl(1, 1, 0, 32'h0400, 1, 0);
        v[15] = idl(1, 0, 0, 32'h0400, 0, 0);
        v[16] = mk(1, 0, 0, 32'h0000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0400, 0, 0);
        v[17] = mk(1, 0, 0, 32'h0000, 0, 7, 0, 1, 0, 0, 7, 1, 0, 1, 0, 32'h0400, 0, 0);
        v[18] = idl(0, 0, 0, 32'h0400, 0, 0);
        v[19] = mk(1, 0, 1, 32'h0500, 9, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 32'h0500, 1, 0);
        rst = 1; clk_en = 1;
        apply(idl(0, 0, 0, 0, 0, 0));
        #2;
        chk("reset_stall", 0, {31'd0, stall}, 32'd0);
        chk_regs(0, 0, 32'h0, 0, 0);
        @(negedge clk); rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            apply(v[i]);
            #1 chk("stall_id", i, {31'd0, stall}, {31'd0, v[i].e_stall});
            @(posedge clk);
            #1 chk_regs(i, v[i].e_red, v[i].e_tgt, v[i].e_flush, v[i].e_mis);
        end
`ifdef BRANCH_STATS_EN
        chk("taken_cnt", 0, tcnt, 32'd4);
        chk("not_taken_cnt", 0, ntcnt, 32'd1);
        chk("stall_cnt", 0, scnt, 32'd2);
`endif
        // async reset while a redirect is pending
        @(negedge clk);
        apply(idl(0, 0, 0, 0, 0, 0));
        rst = 1;
        #1 chk_regs(100, 0, 32'h0, 0, 0);
        chk("rst_stall", 100, {31'd0, stall}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("rst_taken_cnt", 100, tcnt, 32'd0);
`endif
        @(negedge clk); rst = 0;
        apply(mk(1, 0, 1, 32'h0600, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1 chk_regs(101, 1, 32'h0600, 1, 0);
        @(negedge clk); apply(idl(1, 0, 0, 0, 0, 0));
        @(posedge clk); #1 chk_regs(102, 0, 32'h0600, 1, 0);
        @(negedge clk); clk_en = 0;
        @(posedge clk); #1 chk_regs(103, 0, 32'h0600, 1, 0);
        @(posedge clk); #1 chk_regs(104, 0, 32'h0600, 1, 0);
        @(negedge clk); clk_en = 1;
        @(posedge clk); #1 chk_regs(105, 0, 32'h0600, 0, 0);
        @(negedge clk); apply(mk(0, 1, 0, 32'h0006, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1 chk_regs(106, 0, 32'h0600, 0, 1);
        @(negedge clk); clk_en = 0;
        apply(mk(1, 0, 1, 32'h0900, 3, 0, 1, 0, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        #1 chk("gated_stall", 107, {31'd0, stall}, 32'd1);
        @(posedge clk); #1 chk_regs(107, 0, 32'h0600, 0, 1);
        @(negedge clk); clk_en = 1; apply(idl(1, 0, 0, 0, 0, 0));
        @(posedge clk); #1 chk_regs(108, 0, 32'h0600, 0, 0);
        @(negedge clk); apply(mk(1, 0, 1, 32'h0700, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk); apply(idl(1, 0, 0, 0, 0, 0));
        @(posedge clk); #1 chk_regs(109, 0, 32'h0700, 1, 0);
        @(negedge clk); rst = 1;
        #1 chk_regs(110, 0, 32'h0, 0, 0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1 chk_regs(111, 0, 32'h0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the fetch front end around branch resolution in ID.
- Consumes the ID-stage branch decision and target: decoded flags, taken flag and jump address.
- Inserts operand-hazard stalls when the branch comparators would read stale rs1/rs2.
- Issues a held PC-redirect request to the fetch unit, then flushes IF/ID for a programmable number of cycles.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYCLES, 1, cycles of flush_if_id after redirect acceptance; range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  clock enable; low = all state and registers hold
- cbranch_decoded  in  1  conditional branch in ID
- ubranch_decoded  in  1  JAL/JALR in ID
- branch_taken  in  1  taken decision from ID comparators
- jump_address  in  XLEN  computed target
- rs1_addr, rs2_addr  in  5 each  ID source registers
- uses_rs1, uses_rs2  in  1 each  branch reads rs1 / rs2
- ex_rd_addr  in  5  EX destination
- ex_reg_wr  in  1  EX writes rd
- mem_rd_addr  in  5  MEM destination
- mem_is_load  in  1  MEM holds a load
- fetch_ready  in  1  fetch accepts redirect this cycle
- stall_id  out  1  hold PC and IF/ID (combinational)
- pc_redirect  out  1  redirect request (registered)
- pc_target  out  XLEN  redirect target (registered)
- flush_if_id  out  1  squash IF/ID contents (registered)
- misaligned  out  1  one-cycle pulse: taken target not 4-byte aligned

Behaviour:
- States: IDLE, WAIT_OPS, REDIRECT, FLUSH. Encoding is free.
- Reset (async, rst=1): state=IDLE, pc_redirect=0, pc_target=0, flush_if_id=0, misaligned=0, flush counter=0. rst dominates clk_en.
- br = cbranch_decoded | ubranch_decoded.
- hazard = for each used source s (uses_rs1/uses_rs2) with s != x0:
  - (ex_reg_wr & s == ex_rd_addr), or
  - (mem_is_load & s == mem_rd_addr).
- stall_id = (state in {IDLE, WAIT_OPS} & br & hazard) | state == REDIRECT.
- IDLE/WAIT_OPS, br & hazard: go to/stay in WAIT_OPS.
- IDLE/WAIT_OPS, br & !hazard & taken: taken = ubranch_decoded | (cbranch_decoded & branch_taken).
  - tgt = {jump_address[XLEN-1:1], 1'b0}.
  - If tgt[1]=1: misaligned=1 next cycle, no redirect, go to IDLE.
  - Else: pc_target<=tgt, pc_redirect<=1, flush_if_id<=1, go to REDIRECT.
- IDLE/WAIT_OPS, br & !hazard & !taken: go to IDLE, no outputs.
- WAIT_OPS, br drops (external flush): go to IDLE.
- REDIRECT: pc_redirect and pc_target held stable until fetch_ready=1.
  - On acceptance edge: pc_redirect<=0.
  - If FLUSH_CYCLES>0: counter<=FLUSH_CYCLES-1, flush_if_id stays 1, go to FLUSH.
  - Else: flush_if_id<=0, go to IDLE.
- FLUSH: flush_if_id=1; counter decrements each enabled cycle. At 0: flush_if_id<=0, go to IDLE.
- Branches presented in REDIRECT/FLUSH are ignored (instruction is being squashed); stall_id follows the stall_id rule above.
- Latency:
  - Decision edge to pc_redirect=1: 1 cycle.
  - Minimum taken-branch penalty: 1 + FLUSH_CYCLES cycles when fetch_ready is high.
- clk_en=0: no state or register update. stall_id still computed from current inputs. misaligned holds its value.
- misaligned clears on the next enabled cycle.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds outputs taken_cnt, not_taken_cnt, stall_cnt (32-bit each, wrap-around at 2^32-1→0), reset to 0.
  - taken_cnt increments on each redirect launch.
  - not_taken_cnt increments on each resolved not-taken conditional.
  - stall_cnt increments on each enabled cycle with stall_id=1 caused by hazard.
- Undefined: ports and logic absent. Core behaviour is identical.

Test Plan:
- BEQ taken, no hazard, jump_address=0x0000_1000, fetch_ready=1, FLUSH_CYCLES=1 → next cycle pc_redirect=1 and pc_target=0x1000. flush_if_id=1 for 2 cycles, then IDLE, stall_id=0.
- cbranch with rs1_addr=5, uses_rs1=1, ex_reg_wr=1, ex_rd_addr=5 for 1 cycle, taken → stall_id=1 for 1 cycle, then redirect launched. With BRANCH_STATS_EN: stall_cnt=1, taken_cnt=1.
- JALR, jump_address=0x2003 → pc_target=0x2002? No: bit1=1 → misaligned pulse 1 cycle, pc_redirect stays 0.
- JAL to 0x400, fetch_ready low 3 cycles → pc_redirect and pc_target=0x400 stable for 4 cycles, stall_id=1 throughout; released on the fetch_ready edge.
- Hazard on x0 (rs2_addr=0, ex_rd_addr=0, ex_reg_wr=1) → no stall. Not-taken BNE → no redirect, not_taken_cnt +1.
- rst asserted mid-REDIRECT and mid-FLUSH → all outputs 0 immediately (asynchronous), state IDLE. clk_en=0 for 2 cycles during FLUSH extends flush by 2 cycles.
